// File: rtl/ps2_host_tx.sv
// PS/2 host transmitter: Wishbone-programmed command byte sent to a PS/2
// device over open-drain clock/data lines, with ack check and done pulse.
// Ports: wb_clk_i/wb_rst_n_i clock and async active-low reset;
//   wb_adr_i/wb_dat_i/wb_dat_o/wb_we_i/wb_stb_i/wb_cyc_i/wb_ack_o slave bus;
//   wb_tgc_o one-cycle done pulse; ps2_clk_/ps2_data_ open-drain lines.
// Status (adr 1): bit0 busy, bit1 ack error, bit2 timeout, bit3 overrun.
// Option: define PS2_HOST_TIMEOUT_EN to add the transfer watchdog.
module ps2_host_tx #(
  parameter int TIMER_100USEC_VALUE = 1250,
  parameter int TIMER_100USEC_BITS  = 11,
  parameter int TIMEOUT_VALUE       = 187500,
  parameter int TIMEOUT_BITS        = 18
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n_i,
  input  logic       wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_we_i,
  input  logic       wb_stb_i,
  input  logic       wb_cyc_i,
  output logic       wb_ack_o,
  output logic       wb_tgc_o,
  inout  wire        ps2_clk_,
  inout  wire        ps2_data_
);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    STOP,
    ACK,
    WAITIDLE
  } state_e;

  localparam logic [TIMER_100USEC_BITS-1:0] TIMER_LAST =
    TIMER_100USEC_BITS'(TIMER_100USEC_VALUE - 1);

  state_e                        state_q;
  logic                          ack_q;
  logic                          tgc_q;
  logic [7:0]                    dat_q;
  logic [7:0]                    byte_q;
  logic [8:0]                    sh_q;
  logic [3:0]                    bitcnt_q;
  logic [TIMER_100USEC_BITS-1:0] timer_q;
  logic                          clk_oe_q;
  logic                          dat_oe_q;
  logic                          err_q;
  logic                          ovr_q;
  logic [1:0]                    clk_sync_q;
  logic [1:0]                    dat_sync_q;
  logic                          clk_prev_q;
  logic                          to_bit;

`ifdef PS2_HOST_TIMEOUT_EN
  localparam logic [TIMEOUT_BITS-1:0] WD_LAST =
    TIMEOUT_BITS'(TIMEOUT_VALUE - 1);
  logic                          to_q;
  logic [TIMEOUT_BITS-1:0]       wdog_q;
  assign to_bit = to_q;
`else
  assign to_bit = 1'b0;
`endif

  logic       acc;
  logic       wr_acc;
  logic       rd_acc;
  logic       clk_s;
  logic       dat_s;
  logic       fall;
  logic       busy;
  logic [7:0] status;

  // The access commits on the cycle the ack is being registered.
  assign acc    = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr_acc = acc & wb_we_i & ~wb_adr_i;
  assign rd_acc = acc & ~wb_we_i;
  assign clk_s  = clk_sync_q[1];
  assign dat_s  = dat_sync_q[1];
  assign fall   = clk_prev_q & ~clk_s;
  assign busy   = (state_q != IDLE);
  assign status = {4'b0, ovr_q, to_bit, err_q, busy};

  assign wb_ack_o  = ack_q;
  assign wb_tgc_o  = tgc_q;
  assign wb_dat_o  = dat_q;
  assign ps2_clk_  = clk_oe_q ? 1'b0 : 1'bz;
  assign ps2_data_ = dat_oe_q ? 1'b0 : 1'bz;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      tgc_q      <= 1'b0;
      dat_q      <= '0;
      byte_q     <= '0;
      sh_q       <= '0;
      bitcnt_q   <= '0;
      timer_q    <= '0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
`ifdef PS2_HOST_TIMEOUT_EN
      to_q       <= 1'b0;
      wdog_q     <= '0;
`endif
    end else begin
      ack_q      <= acc;
      tgc_q      <= 1'b0;
      clk_sync_q <= {clk_sync_q[0], ps2_clk_};
      dat_sync_q <= {dat_sync_q[0], ps2_data_};
      clk_prev_q <= clk_s;

      if (rd_acc) dat_q <= wb_adr_i ? status : byte_q;

      // Clear first; any set below in the same cycle overrides it.
      if (rd_acc && wb_adr_i) begin
        err_q <= 1'b0;
        ovr_q <= 1'b0;
`ifdef PS2_HOST_TIMEOUT_EN
        to_q  <= 1'b0;
`endif
      end

      if (wr_acc && busy) ovr_q <= 1'b1;

      unique case (state_q)
        IDLE: begin
          if (wr_acc) begin
            byte_q   <= wb_dat_i;
            sh_q     <= {~^wb_dat_i, wb_dat_i};
            timer_q  <= '0;
            clk_oe_q <= 1'b1;
            state_q  <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (timer_q == TIMER_LAST) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b1;
            state_q  <= RTS;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RTS: begin
          bitcnt_q <= '0;
          state_q  <= SHIFT;
        end
        SHIFT: begin
          if (fall) begin
            bitcnt_q <= bitcnt_q + 1'b1;
            if (bitcnt_q == 4'd9) begin
              dat_oe_q <= 1'b0;
              state_q  <= STOP;
            end else begin
              dat_oe_q <= ~sh_q[0];
              sh_q     <= {1'b0, sh_q[8:1]};
            end
          end
        end
        STOP: begin
          if (fall) begin
            if (dat_s) err_q <= 1'b1;
            state_q <= ACK;
          end
        end
        ACK: begin
          if (clk_s && dat_s) state_q <= WAITIDLE;
        end
        WAITIDLE: begin
          tgc_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

`ifdef PS2_HOST_TIMEOUT_EN
      // Watchdog runs from RTS entry until IDLE is reached.
      if (state_q == INHIBIT || state_q == IDLE) begin
        wdog_q <= '0;
      end else if (wdog_q == WD_LAST) begin
        wdog_q   <= '0;
        clk_oe_q <= 1'b0;
        dat_oe_q <= 1'b0;
        to_q     <= 1'b1;
        tgc_q    <= 1'b1;
        state_q  <= IDLE;
      end else begin
        wdog_q <= wdog_q + 1'b1;
      end
`endif
    end
  end

endmodule
